load_align_unit: RTL and testbench

- Parametrised, sequential successor to the combinational load-data shifter in the LSU writeback path.
- Accepts one load descriptor (byte offset, size, sign) from the LSU, then consumes one or two bus read beats from the D-side bus adapter.
- Two beats are needed only for a misaligned access that crosses a bus-word boundary; the unit merges, shifts and sign/zero-extends them.
- Presents a registered result to writeback under a valid/ready handshake. Supports XLEN 32 or 64 and optional trapping of misaligned crossings.

---
 rtl/load_align_unit.sv | 168 ++++++++++++++++
 tb/tb_load_align_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit
//   Sequential load-data aligner for the LSU writeback path. Takes one load
//   descriptor, consumes one bus beat (or two when the access straddles a
//   bus-word boundary), then shifts, merges and extends the bytes. The result
//   is held in a register and handed to writeback under a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous abort of any in-flight load
//   req_valid/req_ready      descriptor handshake
//   req_offset/size/sign     byte offset in bus word, log2 size, sign-extend
//   req_split                combinational: the descriptor needs two beats
//   beat_valid/beat_ready    bus read beat handshake
//   beat_data                bus word, naturally aligned
//   out_valid/out_ready      result handshake
//   out_data, out_err        aligned/extended data, error flag
module load_align_unit #(
    parameter int XLEN        = 64,
    parameter bit MISALIGN_EN = 1'b1,
    localparam int OFF_W      = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OFF_W-1:0] req_offset,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    output logic             req_split,
    input  logic             beat_valid,
    output logic             beat_ready,
    input  logic [XLEN-1:0]  beat_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_err
);

    localparam int NB = XLEN/8;

    typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        logic [1:0]       size;
        logic             sign;
        logic             split;
    } desc_t;

    state_t           state_q, state_d;
    desc_t            desc_q;
    logic [XLEN-1:0]  lo_q;

    // Five bits hold offset + nbytes (max 7 + 8) for either bus width, so the
    // boundary compare never wraps.
    logic [4:0] end_byte;
    logic       req_err;

    always_comb begin
        end_byte  = 5'(req_offset) + (5'd1 << req_size);
        req_split = end_byte > 5'(NB);
        req_err   = (req_split && !MISALIGN_EN) || (req_size == 2'b11 && XLEN == 32);
    end

    // Alignment datapath. In LO an unsplit access sees {0, beat}; in HI the
    // beat on the bus is the upper word and the stored LO beat the lower one.
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   shifted, mask, aligned;
    logic              msb;

    always_comb begin
        merged  = (state_q == HI) ? {beat_data, lo_q} : {{XLEN{1'b0}}, beat_data};
        shifted = XLEN'(merged >> {desc_q.offset, 3'b000});
        case (desc_q.size)
            2'b00:   begin mask = XLEN'(8'hFF);         msb = shifted[7];  end
            2'b01:   begin mask = XLEN'(16'hFFFF);      msb = shifted[15]; end
            2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); msb = shifted[31]; end
            default: begin mask = '1;                   msb = 1'b0;        end
        endcase
        // With a full-width mask ~mask is zero, so word on XLEN=32 and
        // double on XLEN=64 pass through unextended.
        aligned = (shifted & mask) | ((desc_q.sign && msb) ? ~mask : '0);
    end

    // Control
    logic cap_req, cap_lo, ld_res, res_err;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        beat_ready = 1'b0;
        out_valid  = 1'b0;
        cap_req    = 1'b0;
        cap_lo     = 1'b0;
        ld_res     = 1'b0;
        res_err    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cap_req = 1'b1;
                    if (req_err) begin
                        ld_res  = 1'b1;
                        res_err = 1'b1;
                        state_d = OUT;
                    end else begin
                        state_d = LO;
                    end
                end
            end
            LO: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    cap_lo = 1'b1;
                    if (desc_q.split) begin
                        state_d = HI;
                    end else begin
                        ld_res  = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            HI: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    ld_res  = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides every handshake seen this cycle.
        if (flush) begin
            state_d = IDLE;
            cap_req = 1'b0;
            cap_lo  = 1'b0;
            ld_res  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            desc_q   <= '0;
            lo_q     <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_req) desc_q <= '{offset: req_offset, size: req_size,
                                     sign: req_sign, split: req_split};
            if (cap_lo) lo_q <= beat_data;
            if (flush) begin
                out_data <= '0;
                out_err  <= 1'b0;
            end else if (ld_res) begin
                out_data <= res_err ? '0 : aligned;
                out_err  <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a 64-bit merging instance, a 64-bit
// trapping instance (MISALIGN_EN=0) and a 32-bit instance share clock, reset,
// flush and out_ready; each has its own request/beat inputs.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst, flush, out_ready;
    always #5 clk = ~clk;

    // 64-bit, misaligned merge enabled
    logic        req_valid, req_sign, beat_valid;
    logic [2:0]  req_offset;
    logic [1:0]  req_size;
    logic [63:0] beat_data, out_data;
    logic        req_ready, req_split, beat_ready, out_valid, out_err;

    // 64-bit, misaligned trapping
    logic        n_req_valid, n_req_sign, n_beat_valid;
    logic [2:0]  n_req_offset;
    logic [1:0]  n_req_size;
    logic [63:0] n_beat_data, n_out_data;
    logic        n_req_ready, n_req_split, n_beat_ready, n_out_valid, n_out_err;

    // 32-bit
    logic        s_req_valid, s_req_sign, s_beat_valid;
    logic [1:0]  s_req_offset;
    logic [1:0]  s_req_size;
    logic [31:0] s_beat_data, s_out_data;
    logic        s_req_ready, s_req_split, s_beat_ready, s_out_valid, s_out_err;

    load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_offset(req_offset),
        .req_size(req_size), .req_sign(req_sign), .req_split(req_split),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

    load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_offset(n_req_offset),
        .req_size(n_req_size), .req_sign(n_req_sign), .req_split(n_req_split),
        .beat_valid(n_beat_valid), .beat_ready(n_beat_ready), .beat_data(n_beat_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_err(n_out_err));

    load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_offset(s_req_offset),
        .req_size(s_req_size), .req_sign(s_req_sign), .req_split(s_req_split),
        .beat_valid(s_beat_valid), .beat_ready(s_beat_ready), .beat_data(s_beat_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_err(s_out_err));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        req_valid = 0; req_sign = 0; req_offset = 0; req_size = 0; beat_valid = 0; beat_data = 0;
        n_req_valid = 0; n_req_sign = 0; n_req_offset = 0; n_req_size = 0; n_beat_valid = 0; n_beat_data = 0;
        s_req_valid = 0; s_req_sign = 0; s_req_offset = 0; s_req_size = 0; s_beat_valid = 0; s_beat_data = 0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_req_ready",  req_ready,  1'b1);
        check("rst_beat_ready", beat_ready, 1'b0);
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_out_data",   out_data,   64'h0);
        check("rst_out_err",    out_err,    1'b0);

        // Half at offset 3: bytes 3,4 = 0x88,0x44 -> 0x4488, bit 15 clear.
        req_valid = 1; req_offset = 3'd3; req_size = 2'b01; req_sign = 1;
        #1 check("h3_split", req_split, 1'b0);
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'h1122_3344_8877_6655;
        check("h3_beat_ready", beat_ready, 1'b1);
        step();
        beat_valid = 0;
        check("h3_out_valid", out_valid, 1'b1);
        check("h3_out_data",  out_data,  64'h0000_0000_0000_4488);
        check("h3_out_err",   out_err,   1'b0);
        step();
        check("h3_back_idle", req_ready, 1'b1);

        // Half at offset 2: 0x8877 sign-extended.
        req_valid = 1; req_offset = 3'd2; req_size = 2'b01; req_sign = 1;
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'h1122_3344_8877_6655;
        step();
        beat_valid = 0;
        check("h2_out_data", out_data, 64'hFFFF_FFFF_FFFF_8877);
        step();

        // Split word at offset 6.
        req_valid = 1; req_offset = 3'd6; req_size = 2'b10; req_sign = 0;
        #1 check("w6_split", req_split, 1'b1);
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'hAABB_0000_0000_0000;
        step();
        check("w6_hi_valid_low", out_valid, 1'b0);
        check("w6_hi_beat_ready", beat_ready, 1'b1);
        beat_data = 64'h0000_0000_0000_CCDD;
        step();
        beat_valid = 0;
        check("w6_out_valid", out_valid, 1'b1);
        check("w6_out_data",  out_data,  64'h0000_0000_CCDD_AABB);
        step();

        // Boundary split decode.
        req_offset = 3'd7; req_size = 2'b00;
        #1 check("b7_split", req_split, 1'b0);
        req_size = 2'b01;
        #1 check("h7_split", req_split, 1'b1);

        // Double passthrough with writeback stalled.
        out_ready = 0;
        req_valid = 1; req_offset = 3'd0; req_size = 2'b11; req_sign = 1;
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'h8123_4567_89AB_CDEF;
        step();
        beat_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data",  out_data,  64'h8123_4567_89AB_CDEF);
            check("stall_req_ready", req_ready, 1'b0);
            step();
        end
        out_ready = 1;
        step();
        check("stall_release_req_ready", req_ready, 1'b1);
        check("stall_release_valid",     out_valid, 1'b0);

        // Flush while waiting for the HI beat, with a beat presented.
        req_valid = 1; req_offset = 3'd7; req_size = 2'b01; req_sign = 0;
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'h5500_0000_0000_0000;
        step();
        check("fl_in_hi", beat_ready, 1'b1);
        flush = 1; beat_data = 64'h0000_0000_0000_0066;
        step();
        flush = 0; beat_valid = 0;
        check("fl_req_ready",  req_ready,  1'b1);
        check("fl_beat_ready", beat_ready, 1'b0);
        check("fl_out_valid",  out_valid,  1'b0);
        req_valid = 1; req_offset = 3'd0; req_size = 2'b00; req_sign = 1;
        step();
        req_valid = 0; beat_valid = 1; beat_data = 64'h0000_0000_0000_0080;
        step();
        beat_valid = 0;
        check("fl_next_valid", out_valid, 1'b1);
        check("fl_next_data",  out_data,  64'hFFFF_FFFF_FFFF_FF80);
        step();

        // Trapping instance: crossing double at offset 5.
        n_req_valid = 1; n_req_offset = 3'd5; n_req_size = 2'b11; n_req_sign = 0;
        #1 check("n_split", n_req_split, 1'b1);
        step();
        n_req_valid = 0;
        check("n_beat_ready", n_beat_ready, 1'b0);
        check("n_out_valid",  n_out_valid,  1'b1);
        check("n_out_err",    n_out_err,    1'b1);
        check("n_out_data",   n_out_data,   64'h0);
        step();
        check("n_back_idle", n_req_ready, 1'b1);

        // 32-bit instance.
        s_req_valid = 1; s_req_offset = 2'd3; s_req_size = 2'b00; s_req_sign = 0;
        #1 check("s_split", s_req_split, 1'b0);
        step();
        s_req_valid = 0; s_beat_valid = 1; s_beat_data = 32'hAB00_0000;
        step();
        s_beat_valid = 0;
        check("s_out_valid", s_out_valid, 1'b1);
        check("s_out_data",  s_out_data,  32'h0000_00AB);
        check("s_out_err",   s_out_err,   1'b0);
        step();
        s_req_valid = 1; s_req_offset = 2'd0; s_req_size = 2'b11;
        step();
        s_req_valid = 0;
        check("s_dbl_beat_ready", s_beat_ready, 1'b0);
        check("s_dbl_err",        s_out_err,    1'b1);
        check("s_dbl_data",       s_out_data,   32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
